// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory access unit.
// State encoding, request bundle and I/O decode helper.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACC,
    RAM_CAP,
    IO_WAIT,
    DONE
  } state_t;

  localparam logic [15:0] IO_BASE_DEF  = 16'hFF00;
  localparam int          IO_TIMEOUT_DEF = 16;
  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  function automatic logic is_io(
    input logic [15:0] addr,
    input logic [15:0] base
  );
    return addr >= base;
  endfunction

endpackage

// File: rtl/io_timeout_counter.sv
// Counts I/O wait cycles without an acknowledge.
// done flags the cycle whose increment reaches LIMIT.
module io_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign done = enable && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && count != CW'(LIMIT)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding access unit routing requests to RAM or an I/O port.
// I/O accesses are bounded by a wait-cycle timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = IO_BASE_DEF,
  parameter int          IO_TIMEOUT = IO_TIMEOUT_DEF,
  parameter logic [15:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  input  logic        io_ack
);

  state_t state;
  req_t   lat;
  logic   accept;
  logic   tmo_en;
  logic   tmo_done;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;
  assign tmo_en    = (state == IO_WAIT) && !io_ack;

  // Address/data outputs come straight from the latched request
  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;
  assign io_we     = lat.we;
  assign io_addr   = lat.addr[7:0];
  assign io_wdata  = lat.wdata;

  io_timeout_counter #(
    .LIMIT (IO_TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (tmo_en),
    .done   (tmo_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 16'h0000;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      io_req    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat <= '{we: req_we, addr: req_addr, wdata: req_wdata};
            if (is_io(req_addr, IO_BASE)) begin
              state  <= IO_WAIT;
              io_req <= 1'b1;
            end else begin
              state  <= RAM_ACC;
              mem_en <= 1'b1;
              mem_we <= req_we;
            end
          end
        end
        RAM_ACC: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (lat.we) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
          end else begin
            state <= RAM_CAP;
          end
        end
        RAM_CAP: begin
          rsp_rdata <= mem_rdata;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= DONE;
        end
        IO_WAIT: begin
          // An ack in the timeout cycle still completes normally
          if (io_ack) begin
            if (!lat.we) begin
              rsp_rdata <= io_rdata;
            end
            io_req    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= DONE;
          end else if (tmo_done) begin
            io_req    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= ERR_DATA;
            state     <= DONE;
          end
        end
        DONE: begin
          rsp_err <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          io_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        io_ack;

  int checks = 0;
  int errors = 0;
  int hi_cnt;
  int vld_cnt;
  int acc_q[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(
    input logic        we,
    input logic [15:0] addr,
    input logic [15:0] wdata
  );
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic drop();
    req_valid = 1'b0;
    req_we    = ~req_we;
    req_addr  = 16'h0777;
    req_wdata = 16'h9999;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    mem_rdata = '0;
    io_rdata = '0;
    io_ack = 1'b0;
    repeat (2) cyc();
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 16'h0000);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_io_req", io_req, 0);
    reset = 1'b0;
    cyc();

    // RAM write 0x0010 <- 0x1234
    issue(1'b1, 16'h0010, 16'h1234);
    chk("wr_ready", req_ready, 1);
    cyc();
    drop();
    chk("wr_t1_en", mem_en, 1);
    chk("wr_t1_we", mem_we, 1);
    chk("wr_t1_addr", mem_addr, 16'h0010);
    chk("wr_t1_data", mem_wdata, 16'h1234);
    chk("wr_t1_ready", req_ready, 0);
    chk("wr_t1_valid", rsp_valid, 0);
    cyc();
    chk("wr_t2_valid", rsp_valid, 1);
    chk("wr_t2_err", rsp_err, 0);
    chk("wr_t2_en", mem_en, 0);
    chk("wr_t2_we", mem_we, 0);
    chk("wr_t2_rdata", rsp_rdata, 16'h0000);
    cyc();
    chk("wr_t3_valid", rsp_valid, 0);
    chk("wr_t3_ready", req_ready, 1);

    // RAM read 0x0010
    issue(1'b0, 16'h0010, 16'h0000);
    cyc();
    drop();
    chk("rd_t1_en", mem_en, 1);
    chk("rd_t1_we", mem_we, 0);
    chk("rd_t1_addr", mem_addr, 16'h0010);
    cyc();
    mem_rdata = 16'h1234;
    chk("rd_t2_valid", rsp_valid, 0);
    chk("rd_t2_en", mem_en, 0);
    cyc();
    mem_rdata = 16'hBEEF;
    chk("rd_t3_valid", rsp_valid, 1);
    chk("rd_t3_rdata", rsp_rdata, 16'h1234);
    chk("rd_t3_err", rsp_err, 0);
    cyc();
    chk("rd_t4_valid", rsp_valid, 0);
    chk("rd_t4_hold", rsp_rdata, 16'h1234);

    // I/O read 0xFF04, ack after three wait cycles
    issue(1'b0, 16'hFF04, 16'h0000);
    cyc();
    drop();
    chk("ior_req", io_req, 1);
    chk("ior_addr", io_addr, 8'h04);
    chk("ior_we", io_we, 0);
    chk("ior_mem_en", mem_en, 0);
    repeat (2) cyc();
    chk("ior_t3_req", io_req, 1);
    chk("ior_t3_addr", io_addr, 8'h04);
    cyc();
    io_ack = 1'b1;
    io_rdata = 16'h00AB;
    chk("ior_ack_valid", rsp_valid, 0);
    cyc();
    io_ack = 1'b0;
    io_rdata = 16'h0000;
    chk("ior_done_valid", rsp_valid, 1);
    chk("ior_done_rdata", rsp_rdata, 16'h00AB);
    chk("ior_done_err", rsp_err, 0);
    chk("ior_done_req", io_req, 0);
    cyc();
    chk("ior_idle_valid", rsp_valid, 0);

    // I/O write 0xFF00, never acknowledged
    issue(1'b1, 16'hFF00, 16'h4321);
    cyc();
    drop();
    chk("tmo_we", io_we, 1);
    chk("tmo_addr", io_addr, 8'h00);
    chk("tmo_wdata", io_wdata, 16'h4321);
    hi_cnt = 0;
    vld_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (io_req) hi_cnt++;
      if (rsp_valid) vld_cnt++;
      cyc();
    end
    chk("tmo_req_cycles", hi_cnt, 16);
    chk("tmo_early_valid", vld_cnt, 0);
    chk("tmo_valid", rsp_valid, 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_rdata", rsp_rdata, 16'hDEAD);
    chk("tmo_req_low", io_req, 0);
    cyc();
    chk("tmo_after_valid", rsp_valid, 0);
    chk("tmo_after_err", rsp_err, 0);

    // RAM write leaves rsp_rdata untouched
    issue(1'b1, 16'h0020, 16'h5555);
    cyc();
    drop();
    repeat (2) cyc();
    chk("wr2_keep_rdata", rsp_rdata, 16'hDEAD);

    // I/O read acked exactly in the 16th wait cycle
    issue(1'b0, 16'hFF10, 16'h0000);
    cyc();
    drop();
    repeat (15) cyc();
    io_ack = 1'b1;
    io_rdata = 16'h5A5A;
    chk("edge_req", io_req, 1);
    chk("edge_no_valid", rsp_valid, 0);
    cyc();
    io_ack = 1'b0;
    io_rdata = 16'h0000;
    chk("edge_valid", rsp_valid, 1);
    chk("edge_err", rsp_err, 0);
    chk("edge_rdata", rsp_rdata, 16'h5A5A);
    cyc();

    // Reset during IO_WAIT aborts the access
    issue(1'b0, 16'hFF08, 16'h0000);
    cyc();
    drop();
    chk("abort_req_hi", io_req, 1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_req_low", io_req, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_rdata", rsp_rdata, 16'h0000);
    io_ack = 1'b1;
    io_rdata = 16'hFFFF;
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (rsp_valid) vld_cnt++;
    end
    io_ack = 1'b0;
    chk("stray_ack_valid", vld_cnt, 0);
    chk("stray_ack_rdata", rsp_rdata, 16'h0000);

    // req_valid held high with back-to-back RAM writes
    issue(1'b1, 16'h0030, 16'h00C3);
    vld_cnt = 0;
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc_q.push_back(i);
      if (rsp_valid) vld_cnt++;
      if (rsp_valid && req_ready) hi_cnt++;
      cyc();
    end
    drop();
    chk("b2b_accepts", acc_q.size(), 4);
    if (acc_q.size() >= 2) begin
      chk("b2b_first", acc_q[0], 0);
      chk("b2b_gap", acc_q[1] - acc_q[0], 3);
    end
    chk("b2b_done_cnt", vld_cnt, 4);
    chk("b2b_overlap", hi_cnt, 0);
    cyc();
    chk("b2b_idle", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
